shift_sequencer: RTL



---
 rtl/shift_sequencer_pkg.sv | 23 ++
 rtl/shift_sequencer_shift32.sv | 15 +
 rtl/shift_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared opcode constants, sequencer state encoding and the PASS2 amount helper
// for the shift sequencer front end.
package shift_sequencer_pkg;

    localparam logic [2:0] SHOP_SLL = 3'b000;
    localparam logic [2:0] SHOP_SRL = 3'b001;
    localparam logic [2:0] SHOP_SRA = 3'b010;
    localparam logic [2:0] SHOP_ROL = 3'b011;
    localparam logic [2:0] SHOP_ROR = 3'b100;

    typedef enum logic [1:0] {
        SSQ_IDLE  = 2'd0,
        SSQ_PASS1 = 2'd1,
        SSQ_PASS2 = 2'd2,
        SSQ_DONE  = 2'd3
    } ssq_state_e;

    // k = 32 - s; s==0 yields 32, which the shifter saturates to zero.
    function automatic logic [5:0] pass2_amount(input logic [4:0] s);
        return 6'd32 - {1'b0, s};
    endfunction

endpackage

// File: rtl/shift_sequencer_shift32.sv
// Combinational 32-bit logical shifter; amounts >= 32 saturate to zero.
module shift_sequencer_shift32 (
    input  logic [31:0] data,
    input  logic [31:0] amount,
    input  logic        lnr,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        if (amount[31:5] == '0)
            y = lnr ? (data << amount[4:0]) : (data >> amount[4:0]);
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA/ROL/ROR sequencer built from one or two passes
// through a single logical shifter, OR-accumulating into ACC.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter bit SKIP_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [2:0]  OP,
    input  logic [31:0] D,
    input  logic [31:0] S,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] RESULT,
    output logic        ERR
);

    ssq_state_e  state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] d_q, s_q, acc_q, pass1_acc;
    logic        err_q;

    logic [31:0] sh_data, sh_amt, sh_y;
    logic        sh_lnr;
    logic        s_ge32, is_rot, is_legal;

    assign s_ge32   = |s_q[31:5];
    assign is_rot   = (op_q == SHOP_ROL) || (op_q == SHOP_ROR);
    assign is_legal = (op_q <= SHOP_ROR);

    shift_sequencer_shift32 u_shift32 (
        .data   (sh_data),
        .amount (sh_amt),
        .lnr    (sh_lnr),
        .y      (sh_y)
    );

    always_comb begin
        state_d   = state_q;
        sh_data   = '0;
        sh_amt    = '0;
        sh_lnr    = 1'b0;
        pass1_acc = sh_y;
        unique case (state_q)
            SSQ_IDLE: if (IN_VALID) state_d = SSQ_PASS1;
            SSQ_PASS1: begin
                sh_data = d_q;
                sh_lnr  = (op_q == SHOP_SLL) || (op_q == SHOP_ROL);
                sh_amt  = is_rot ? {27'b0, s_q[4:0]} : s_q;
                state_d = SSQ_DONE;
                case (op_q)
                    SHOP_SLL, SHOP_SRL: ;
                    SHOP_SRA: begin
                        if (s_ge32)
                            pass1_acc = {32{d_q[31]}};
                        else if (!(SKIP_EN && !d_q[31]))
                            state_d = SSQ_PASS2;
                    end
                    SHOP_ROL, SHOP_ROR: begin
                        if (!(SKIP_EN && (s_q[4:0] == 5'd0)))
                            state_d = SSQ_PASS2;
                    end
                    default: pass1_acc = d_q;
                endcase
            end
            SSQ_PASS2: begin
                // SRA fill is the sign replicated, so a positive operand adds
                // nothing when the early-out is disabled.
                sh_data = (op_q == SHOP_SRA) ? {32{d_q[31]}} : d_q;
                sh_lnr  = (op_q != SHOP_ROL);
                sh_amt  = {26'b0, pass2_amount(s_q[4:0])};
                state_d = SSQ_DONE;
            end
            SSQ_DONE: if (OUT_READY) state_d = SSQ_IDLE;
            default:  state_d = SSQ_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SSQ_IDLE;
            op_q    <= '0;
            d_q     <= '0;
            s_q     <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == SSQ_IDLE && IN_VALID) begin
                op_q <= OP;
                d_q  <= D;
                s_q  <= S;
            end
            if (state_q == SSQ_PASS1) begin
                acc_q <= pass1_acc;
                err_q <= !is_legal;
            end
            if (state_q == SSQ_PASS2)
                acc_q <= acc_q | sh_y;
        end
    end

    assign IN_READY  = (state_q == SSQ_IDLE);
    assign OUT_VALID = (state_q == SSQ_DONE);
    assign RESULT    = acc_q;
    assign ERR       = err_q;

endmodule
